// File: rtl/wb_dbus_arbiter_wdt.sv
// wb_dbus_arbiter_wdt: two-master Wishbone dbus arbiter (index 1 = or1k_d, 0 = dbg)
// with a watchdog that aborts unanswered strobes with err after TIMEOUT cycles.
module wb_dbus_arbiter_wdt #(
  parameter int DW       = 32,
  parameter int AW       = 32,
  parameter int TIMEOUT  = 1023,
  parameter int DBG_PRIO = 1
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [2*AW-1:0]   wbm_adr_i,
  input  logic [2*DW-1:0]   wbm_dat_i,
  input  logic [2*DW/8-1:0] wbm_sel_i,
  input  logic [5:0]        wbm_cti_i,
  input  logic [3:0]        wbm_bte_i,
  input  logic [1:0]        wbm_we_i,
  input  logic [1:0]        wbm_cyc_i,
  input  logic [1:0]        wbm_stb_i,
  output logic [2*DW-1:0]   wbm_dat_o,
  output logic [1:0]        wbm_ack_o,
  output logic [1:0]        wbm_err_o,
  output logic [1:0]        wbm_rty_o,
  output logic [AW-1:0]     wbs_adr_o,
  output logic [DW-1:0]     wbs_dat_o,
  output logic [DW/8-1:0]   wbs_sel_o,
  output logic [2:0]        wbs_cti_o,
  output logic [1:0]        wbs_bte_o,
  output logic              wbs_we_o,
  output logic              wbs_cyc_o,
  output logic              wbs_stb_o,
  input  logic [DW-1:0]     wbs_dat_i,
  input  logic              wbs_ack_i,
  input  logic              wbs_err_i,
  input  logic              wbs_rty_i,
  output logic [1:0]        grant_o,
  output logic              timeout_o
);
  localparam int SW = DW / 8;
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CMAX = CW'(TIMEOUT);
  typedef enum logic [1:0] {IDLE, OWNED, ABORT} state_t;
  state_t          st_q, st_d;
  logic [1:0]      grant_q, grant_d;
  logic            last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            own, resp, win, hit;
  assign own  = grant_q[1];
  assign resp = wbs_ack_i | wbs_err_i | wbs_rty_i;
  // on a tie, round-robin hands the bus to whoever did not own it last
  assign win  = wbm_cyc_i == 2'b11 ? (DBG_PRIO != 0 ? 1'b0 : !last_q) : wbm_cyc_i[1];
  assign hit  = TIMEOUT != 0 && cnt_q == CMAX && !resp;
  assign grant_o   = grant_q;
  assign timeout_o = st_q == ABORT;
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      st_q    <= IDLE;
      grant_q <= '0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      st_q    <= st_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    st_d    = st_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = '0;
    case (st_q)
      IDLE: if (|wbm_cyc_i) begin
        st_d    = OWNED;
        grant_d = win ? 2'b10 : 2'b01;
        last_d  = win;
      end
      OWNED: if (!wbm_cyc_i[own]) begin
        st_d    = IDLE;
        grant_d = '0;
      end else if (hit) begin
        st_d = ABORT;
      end else begin
        cnt_d = (!wbm_stb_i[own] || resp) ? '0 : cnt_q + CW'(cnt_q != CMAX);
      end
      default: begin
        st_d    = IDLE;
        grant_d = '0;
      end
    endcase
  end
  always_comb begin
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    wbs_cti_o = '0;
    wbs_bte_o = '0;
    wbs_we_o  = 1'b0;
    wbs_cyc_o = 1'b0;
    wbs_stb_o = 1'b0;
    wbm_dat_o = '0;
    wbm_ack_o = '0;
    wbm_err_o = '0;
    wbm_rty_o = '0;
    if (st_q == OWNED) begin
      wbs_adr_o = own ? wbm_adr_i[2*AW-1:AW] : wbm_adr_i[AW-1:0];
      wbs_dat_o = own ? wbm_dat_i[2*DW-1:DW] : wbm_dat_i[DW-1:0];
      wbs_sel_o = own ? wbm_sel_i[2*SW-1:SW] : wbm_sel_i[SW-1:0];
      wbs_cti_o = own ? wbm_cti_i[5:3] : wbm_cti_i[2:0];
      wbs_bte_o = own ? wbm_bte_i[3:2] : wbm_bte_i[1:0];
      wbs_we_o  = wbm_we_i[own];
      wbs_cyc_o = wbm_cyc_i[own];
      wbs_stb_o = wbm_stb_i[own];
      wbm_dat_o = own ? {wbs_dat_i, {DW{1'b0}}} : {{DW{1'b0}}, wbs_dat_i};
      wbm_ack_o = {own, !own} & {2{wbs_ack_i}};
      wbm_err_o = {own, !own} & {2{wbs_err_i}};
      wbm_rty_o = {own, !own} & {2{wbs_rty_i}};
    end else if (st_q == ABORT) begin
      wbm_err_o = {own, !own};
    end
  end
endmodule

// File: tb/tb_wb_dbus_arbiter_wdt.sv
// tb_wb_dbus_arbiter_wdt: directed checks of arbitration, pass-through and watchdog.
module tb_wb_dbus_arbiter_wdt;
  logic        clk = 1'b0, rst = 1'b1;
  logic [63:0] adr, dat;
  logic [7:0]  sel;
  logic [5:0]  cti;
  logic [3:0]  bte;
  logic [1:0]  we, cyc, stb;
  logic [31:0] s_dat;
  logic        s_ack, s_err, s_rty;
  logic [63:0] a_mdat, b_mdat;
  logic [1:0]  a_ack, a_err, a_rty, b_ack, b_err, b_rty, a_grant, b_grant;
  logic [31:0] a_adr, a_dat, b_adr, b_dat;
  logic [3:0]  a_sel, b_sel;
  logic [2:0]  a_cti, b_cti;
  logic [1:0]  a_bte, b_bte;
  logic        a_we, a_cyc, a_stb, a_to, b_we, b_cyc, b_stb, b_to;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  wb_dbus_arbiter_wdt #(.TIMEOUT(8), .DBG_PRIO(1)) u0 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbm_adr_i(adr), .wbm_dat_i(dat), .wbm_sel_i(sel),
    .wbm_cti_i(cti), .wbm_bte_i(bte), .wbm_we_i(we), .wbm_cyc_i(cyc), .wbm_stb_i(stb),
    .wbm_dat_o(a_mdat), .wbm_ack_o(a_ack), .wbm_err_o(a_err), .wbm_rty_o(a_rty),
    .wbs_adr_o(a_adr), .wbs_dat_o(a_dat), .wbs_sel_o(a_sel), .wbs_cti_o(a_cti), .wbs_bte_o(a_bte),
    .wbs_we_o(a_we), .wbs_cyc_o(a_cyc), .wbs_stb_o(a_stb), .wbs_dat_i(s_dat), .wbs_ack_i(s_ack),
    .wbs_err_i(s_err), .wbs_rty_i(s_rty), .grant_o(a_grant), .timeout_o(a_to));
  wb_dbus_arbiter_wdt #(.TIMEOUT(0), .DBG_PRIO(0)) u1 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbm_adr_i(adr), .wbm_dat_i(dat), .wbm_sel_i(sel),
    .wbm_cti_i(cti), .wbm_bte_i(bte), .wbm_we_i(we), .wbm_cyc_i(cyc), .wbm_stb_i(stb),
    .wbm_dat_o(b_mdat), .wbm_ack_o(b_ack), .wbm_err_o(b_err), .wbm_rty_o(b_rty),
    .wbs_adr_o(b_adr), .wbs_dat_o(b_dat), .wbs_sel_o(b_sel), .wbs_cti_o(b_cti), .wbs_bte_o(b_bte),
    .wbs_we_o(b_we), .wbs_cyc_o(b_cyc), .wbs_stb_o(b_stb), .wbs_dat_i(s_dat), .wbs_ack_i(s_ack),
    .wbs_err_i(s_err), .wbs_rty_i(s_rty), .grant_o(b_grant), .timeout_o(b_to));
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_inputs();
    adr = {32'h0000_0040, 32'h0000_0010};
    dat = {32'h1111_1111, 32'h2222_2222};
    sel = 8'hff; cti = '0; bte = '0; we = '0; cyc = '0; stb = '0;
    s_dat = '0; s_ack = 0; s_err = 0; s_rty = 0;
  endtask
  task automatic do_reset();
    idle_inputs();
    rst = 1;
    step();
    step();
    rst = 0;
  endtask
  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (a_grant !== 2'b00) begin errors++; $display("FAIL reset_grant got %b exp 00", a_grant); end
    checks++; if ({a_cyc, a_stb, a_we, a_adr} !== '0) begin errors++; $display("FAIL reset_wbs got %b%b%b %h exp 0", a_cyc, a_stb, a_we, a_adr); end
    checks++; if ({a_ack, a_err, a_rty, a_to} !== '0) begin errors++; $display("FAIL reset_resp got %b %b %b %b exp 0", a_ack, a_err, a_rty, a_to); end
    checks++; if (a_mdat !== '0) begin errors++; $display("FAIL reset_mdat got %h exp 0", a_mdat); end
  endtask
  task automatic test_single();
    do_reset();
    cyc = 2'b10; stb = 2'b10;
    #1;
    checks++; if (a_cyc !== 1'b0) begin errors++; $display("FAIL single_latency got %b exp 0", a_cyc); end
    step();
    checks++; if (a_grant !== 2'b10) begin errors++; $display("FAIL single_grant got %b exp 10", a_grant); end
    checks++; if ({a_cyc, a_stb, a_adr} !== {2'b11, 32'h40}) begin errors++; $display("FAIL single_pass got %b%b %h exp 11 00000040", a_cyc, a_stb, a_adr); end
    step();
    step();
    s_ack = 1; s_dat = 32'hDEADBEEF;
    #1;
    checks++; if (a_ack !== 2'b10) begin errors++; $display("FAIL single_ack got %b exp 10", a_ack); end
    checks++; if (a_mdat !== {32'hDEADBEEF, 32'h0}) begin errors++; $display("FAIL single_dat got %h exp deadbeef00000000", a_mdat); end
    step();
    s_ack = 0; cyc = 0; stb = 0;
    #1;
    checks++; if (a_cyc !== 1'b0) begin errors++; $display("FAIL single_drop got %b exp 0", a_cyc); end
    step();
    checks++; if (a_grant !== 2'b00) begin errors++; $display("FAIL single_release got %b exp 00", a_grant); end
  endtask
  task automatic test_priority();
    do_reset();
    cyc = 2'b11; stb = 2'b11;
    step();
    s_ack = 1; s_dat = 32'h0000_5A5A;
    #1;
    checks++; if (a_grant !== 2'b01) begin errors++; $display("FAIL prio_grant got %b exp 01", a_grant); end
    checks++; if (a_adr !== 32'h10) begin errors++; $display("FAIL prio_adr got %h exp 00000010", a_adr); end
    checks++; if ({a_ack, a_mdat} !== {2'b01, 64'h5A5A}) begin errors++; $display("FAIL prio_ack got %b %h exp 01 0000000000005a5a", a_ack, a_mdat); end
    step();
    s_ack = 0; cyc = 2'b10; stb = 2'b10;
    #1;
    checks++; if (a_cyc !== 1'b0) begin errors++; $display("FAIL prio_drop got %b exp 0", a_cyc); end
    step();
    checks++; if (a_grant !== 2'b00) begin errors++; $display("FAIL prio_gap got %b exp 00", a_grant); end
    step();
    checks++; if ({a_grant, a_adr} !== {2'b10, 32'h40}) begin errors++; $display("FAIL prio_next got %b %h exp 10 00000040", a_grant, a_adr); end
    cyc = 0; stb = 0;
    step();
  endtask
  task automatic test_round_robin();
    logic [1:0] e;
    do_reset();
    cyc = 2'b01; stb = 2'b01;
    step();
    s_ack = 1;
    step();
    s_ack = 0; cyc = 0; stb = 0;
    step();
    cyc = 2'b11; stb = 2'b11;
    for (int k = 0; k < 4; k++) begin
      e = k % 2 == 0 ? 2'b10 : 2'b01;
      step();
      s_ack = 1;
      #1;
      checks++; if (b_grant !== e) begin errors++; $display("FAIL rr_grant%0d got %b exp %b", k, b_grant, e); end
      checks++; if (b_ack !== e) begin errors++; $display("FAIL rr_ack%0d got %b exp %b", k, b_ack, e); end
      step();
      s_ack = 0; cyc = ~e; stb = ~e;
      step();
      cyc = 2'b11; stb = 2'b11;
      #1;
      checks++; if (b_grant !== 2'b00) begin errors++; $display("FAIL rr_gap%0d got %b exp 00", k, b_grant); end
    end
    cyc = 0; stb = 0;
    step();
  endtask
  task automatic test_timeout();
    int n;
    do_reset();
    cyc = 2'b10; stb = 2'b10; we = 2'b10;
    n = 0;
    repeat (20) begin
      step();
      if (!a_stb) break;
      n++;
    end
    checks++; if (n !== 9) begin errors++; $display("FAIL wdt_stb_cycles got %0d exp 9", n); end
    s_ack = 1;
    #1;
    checks++; if ({a_cyc, a_err, a_ack, a_to} !== {1'b0, 2'b10, 2'b00, 1'b1}) begin errors++; $display("FAIL wdt_abort got cyc %b err %b ack %b to %b exp 0 10 00 1", a_cyc, a_err, a_ack, a_to); end
    checks++; if ({b_stb, b_to} !== 2'b10) begin errors++; $display("FAIL wdt_disabled got stb %b to %b exp 1 0", b_stb, b_to); end
    step();
    s_ack = 0;
    #1;
    checks++; if ({a_grant, a_to} !== 3'b000) begin errors++; $display("FAIL wdt_after got grant %b to %b exp 00 0", a_grant, a_to); end
    cyc = 0; stb = 0; we = 0;
    step();
    step();
    cyc = 2'b10; stb = 2'b10;
    repeat (9) step();
    s_ack = 1;
    #1;
    checks++; if ({a_ack, a_err} !== {2'b10, 2'b00}) begin errors++; $display("FAIL wdt_edge_ack got ack %b err %b exp 10 00", a_ack, a_err); end
    step();
    s_ack = 0; cyc = 0; stb = 0;
    #1;
    checks++; if (a_to !== 1'b0) begin errors++; $display("FAIL wdt_edge_noabort got %b exp 0", a_to); end
    step();
  endtask
  task automatic test_burst();
    logic [2:0] c;
    do_reset();
    cyc = 2'b10; stb = 2'b10; cti = 6'b010_000;
    step();
    cyc = 2'b11; stb = 2'b11;
    for (int k = 0; k < 4; k++) begin
      c = k == 3 ? 3'b111 : 3'b010;
      cti = {c, 3'b000}; s_ack = 1;
      #1;
      checks++; if ({a_grant, a_ack, a_cti} !== {2'b10, 2'b10, c}) begin errors++; $display("FAIL burst_beat%0d got grant %b ack %b cti %b exp 10 10 %b", k, a_grant, a_ack, a_cti, c); end
      step();
    end
    s_ack = 0; cyc = 2'b01; stb = 2'b01; cti = '0;
    #1;
    checks++; if ({a_cyc, a_grant} !== {1'b0, 2'b10}) begin errors++; $display("FAIL burst_drop got cyc %b grant %b exp 0 10", a_cyc, a_grant); end
    step();
    checks++; if (a_grant !== 2'b00) begin errors++; $display("FAIL burst_gap got %b exp 00", a_grant); end
    step();
    checks++; if ({a_grant, a_adr} !== {2'b01, 32'h10}) begin errors++; $display("FAIL burst_dbg got %b %h exp 01 00000010", a_grant, a_adr); end
    cyc = 0; stb = 0;
    step();
  endtask
  task automatic test_reset_mid();
    do_reset();
    cyc = 2'b10; stb = 2'b10;
    step();
    step();
    rst = 1;
    step();
    s_ack = 1;
    #1;
    checks++; if ({a_grant, a_cyc} !== 3'b000) begin errors++; $display("FAIL rstmid_state got grant %b cyc %b exp 00 0", a_grant, a_cyc); end
    checks++; if ({a_ack, a_err, a_rty} !== '0) begin errors++; $display("FAIL rstmid_resp got %b %b %b exp 00 00 00", a_ack, a_err, a_rty); end
    rst = 0; s_ack = 0; cyc = 0; stb = 0;
    step();
  endtask
  initial begin
    test_reset();
    test_single();
    test_priority();
    test_round_robin();
    test_timeout();
    test_burst();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_dbus_arbiter_wdt.md
Name: wb_dbus_arbiter_wdt

Overview:
Two-master Wishbone arbiter with a bus watchdog. It shares the single dbus slave port between the or1k data master and the debug master. It grants ownership for a whole cyc, using fixed-priority or round-robin selection. It aborts with err any transfer the slave fails to answer within TIMEOUT cycles, so a hung peripheral cannot lock out the debug unit.

Parameters:
DW, 32, data width
AW, 32, address width
TIMEOUT, 1023, max cycles owner stb may wait for ack/err/rty; 0 disables watchdog
DBG_PRIO, 1, 1: dbg wins simultaneous requests; 0: round-robin

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  synchronous active-high reset
wbm_adr_i  in  2*AW  master addresses, packed {or1k_d, dbg}; index 1 = or1k_d, index 0 = dbg (same for all wbm_* vectors)
wbm_dat_i  in  2*DW  master write data
wbm_sel_i  in  2*DW/8  master byte selects
wbm_cti_i  in  2*3  master cycle type
wbm_bte_i  in  2*2  master burst type
wbm_we_i, wbm_cyc_i, wbm_stb_i  in  2 each  master we/cyc/stb
wbm_dat_o  out  2*DW  read data to masters
wbm_ack_o, wbm_err_o, wbm_rty_o  out  2 each  responses to masters
wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_cti_o, wbs_bte_o  out  AW/DW/DW/8/3/2  to dbus slave
wbs_we_o, wbs_cyc_o, wbs_stb_o  out  1 each  to dbus slave
wbs_dat_i  in  DW  slave read data
wbs_ack_i, wbs_err_i, wbs_rty_i  in  1 each  slave responses
grant_o  out  2  registered one-hot owner, 0 when idle
timeout_o  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (sync, wins over everything):
  - state IDLE, grant_o=0, watchdog counter=0, last_owner=or1k_d (index 1).
  - All wbs_* outputs 0; all wbm ack/err/rty 0; wbm_dat_o 0; timeout_o 0.
- State IDLE:
  - Slave outputs all 0.
  - If any wbm_cyc_i is set, register the winner into grant_o and go to OWNED. Slave cyc is therefore seen the cycle after master cyc (1-cycle arbitration latency).
  - Single requester: that master wins.
  - Both requesting, DBG_PRIO=1: dbg wins.
  - Both requesting, DBG_PRIO=0: the master that is not last_owner wins.
- State OWNED:
  - Owner's adr/dat/sel/we/cyc/stb/cti/bte pass combinationally to wbs_*.
  - Slave dat/ack/err/rty pass combinationally to the owner's slice only.
  - Non-owner receives ack/err/rty=0 and dat 0.
  - last_owner is updated on grant.
- Watchdog counter (width clog2(TIMEOUT+1)):
  - Cleared when owner stb=0, or on any ack/err/rty.
  - Otherwise increments by 1 while owner stb=1.
  - Saturates; never wraps.
- Leaving OWNED:
  - Owner cyc=0 in cycle N: wbs_cyc_o=0 in N (pass-through), state IDLE at N+1.
  - So at least one idle cycle separates owners. No preemption mid-cyc, including bursts (cti 010 holds the grant).
- Timeout (TIMEOUT!=0 and counter==TIMEOUT while no response) in cycle N: state ABORT at N+1.
- State ABORT (exactly 1 cycle):
  - wbs_cyc_o=wbs_stb_o=0.
  - Owner wbm_err_o=1, ack=rty=0; timeout_o=1.
  - Any slave response in this cycle is discarded.
  - Next state IDLE; grant_o cleared.
  - If the old owner keeps cyc, it re-arbitrates normally.
- A response arriving on the same cycle the counter hits TIMEOUT is forwarded; no abort occurs.
- Simultaneous owner cyc drop and slave ack: ack forwarded, go IDLE.
- TIMEOUT=0: ABORT is unreachable; timeout_o stays 0.

Test Plan:
- Reset then or1k_d single read, adr 0x00000040, slave acks 2 cycles after wbs_stb_o with dat 0xDEADBEEF -> grant_o=2'b10 one cycle after cyc; wbm_dat_o[63:32]=0xDEADBEEF with wbm_ack_o=2'b10; dbg slice ack 0.
- Both masters raise cyc in same cycle, DBG_PRIO=1 -> grant_o=2'b01. After dbg drops cyc: one idle cycle, then grant_o=2'b10.
- DBG_PRIO=0, both masters continuously requesting single transfers -> grants alternate 10,01,10,01 with one idle cycle between.
- TIMEOUT=8, slave never acks an or1k_d write -> wbs_stb_o high 9 cycles. Then ABORT cycle: wbs_cyc_o=0, wbm_err_o=2'b10, timeout_o=1 for one cycle, grant_o=0 next cycle.
- or1k_d 4-beat incrementing burst (cti 010…111) while dbg requests -> dbg stays ungranted until or1k_d cyc drops; then dbg granted after one idle cycle.
- wb_rst_i asserted mid-transfer while owned -> next edge: grant_o=0, wbs_cyc_o=0, all acks 0, counter 0. A late slave ack is not forwarded.
